// File: rtl/bsg_acm_array_ctrl.sv
// bsg_acm_array_ctrl: sequencer for a width_p x height_p ACM pixel-cell array.
// Frame flow: IDLE -> LOAD (one row per beat) -> RUN (iters enable cycles)
// -> DRAIN (stream rows out) -> IDLE with a one-cycle done_o pulse.
// Optional feature macro: BSG_ACM_CTRL_ABORT_EN adds abort_i, which drops any
// in-flight frame back to IDLE without a done_o pulse.
module bsg_acm_array_ctrl #(
   parameter  int width_p      = 8,
   parameter  int height_p     = 8,
   parameter  int iter_width_p = 16,
   localparam int row_w_lp     = (height_p > 1) ? $clog2(height_p) : 1
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
`ifdef BSG_ACM_CTRL_ABORT_EN
   input  logic                    abort_i,
`endif
   input  logic                    cfg_v_i,
   input  logic [iter_width_p-1:0] cfg_iters_i,
   output logic                    busy_o,
   input  logic                    load_v_i,
   input  logic [width_p-1:0]      load_data_i,
   output logic                    load_ready_o,
   output logic [height_p-1:0]     update_row_o,
   output logic [width_p-1:0]      update_val_o,
   output logic                    en_o,
   output logic [row_w_lp-1:0]     rd_row_o,
   input  logic [width_p-1:0]      rd_data_i,
   output logic                    out_v_o,
   output logic [width_p-1:0]      out_data_o,
   input  logic                    out_yumi_i,
   output logic                    done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_e;

   state_e                  state_q, state_n;
   logic [row_w_lp-1:0]     row_q, row_n;
   logic [iter_width_p-1:0] iter_q, iter_n;
   logic [iter_width_p-1:0] iters_q, iters_n;
   logic                    done_q, done_n;
   logic                    beat;
   logic                    row_last;
   logic                    abort_w;

`ifdef BSG_ACM_CTRL_ABORT_EN
   assign abort_w = abort_i;
`else
   assign abort_w = 1'b0;
`endif

   assign row_last = (row_q == row_w_lp'(height_p - 1));

   // Next-state and control outputs; abort overrides everything outside IDLE.
   always_comb begin
      state_n      = state_q;
      row_n        = row_q;
      iter_n       = iter_q;
      iters_n      = iters_q;
      done_n       = 1'b0;
      load_ready_o = 1'b0;
      en_o         = 1'b0;
      out_v_o      = 1'b0;
      beat         = 1'b0;
      case (state_q)
         IDLE: begin
            // abort held in IDLE suppresses a simultaneous start request
            if (cfg_v_i && !abort_w) begin
               iters_n = cfg_iters_i;
               row_n   = '0;
               state_n = LOAD;
            end
         end
         LOAD: begin
            load_ready_o = 1'b1;
            beat         = load_v_i;
            if (beat) begin
               if (row_last) begin
                  row_n   = '0;
                  iter_n  = iters_q;
                  state_n = (iters_q != '0) ? RUN : DRAIN;
               end else begin
                  row_n = row_q + row_w_lp'(1);
               end
            end
         end
         RUN: begin
            en_o = 1'b1;
            if (iter_q == iter_width_p'(1)) begin
               iter_n  = '0;
               state_n = DRAIN;
            end else begin
               iter_n = iter_q - iter_width_p'(1);
            end
         end
         DRAIN: begin
            out_v_o = 1'b1;
            if (out_yumi_i) begin
               if (row_last) begin
                  row_n   = '0;
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  row_n = row_q + row_w_lp'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (abort_w && (state_q != IDLE)) begin
         state_n = IDLE;
         row_n   = '0;
         iter_n  = '0;
         done_n  = 1'b0;
      end
   end

   // State, counters, latched iteration count and done pulse.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         row_q   <= '0;
         iter_q  <= '0;
         iters_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         row_q   <= row_n;
         iter_q  <= iter_n;
         iters_q <= iters_n;
         done_q  <= done_n;
      end
   end

   // One-hot row strobe, qualified by the load beat so cells capture in-edge.
   for (genvar r = 0; r < height_p; r++) begin : g_row
      assign update_row_o[r] = beat & (row_q == row_w_lp'(r));
   end

   assign busy_o       = (state_q != IDLE);
   assign update_val_o = load_data_i;
   assign rd_row_o     = row_q;
   assign out_data_o   = rd_data_i;
   assign done_o       = done_q;

`ifndef SYNTHESIS
   // Consumer may only take a row that is being offered.
   always @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(out_yumi_i && !out_v_o))
            else $error("bsg_acm_array_ctrl: out_yumi_i asserted without out_v_o");
      end
   end
`endif

endmodule

// File: tb/tb_bsg_acm_array_ctrl.sv
// Bench for bsg_acm_array_ctrl: behavioural cell array (enable = rotate row
// left by one), directed frames, scoreboard queue of expected output rows.
module tb_bsg_acm_array_ctrl;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int IW = 16;

   logic          clk_i = 1'b0;
   logic          reset_n_i;
`ifdef BSG_ACM_CTRL_ABORT_EN
   logic          abort_i;
`endif
   logic          cfg_v_i;
   logic [IW-1:0] cfg_iters_i;
   logic          busy_o;
   logic          load_v_i;
   logic [W-1:0]  load_data_i;
   logic          load_ready_o;
   logic [H-1:0]  update_row_o;
   logic [W-1:0]  update_val_o;
   logic          en_o;
   logic [2:0]    rd_row_o;
   logic [W-1:0]  rd_data_i;
   logic          out_v_o;
   logic [W-1:0]  out_data_o;
   logic          out_yumi_i;
   logic          done_o;

   bsg_acm_array_ctrl #(.width_p(W), .height_p(H), .iter_width_p(IW)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
`ifdef BSG_ACM_CTRL_ABORT_EN
      .abort_i(abort_i),
`endif
      .cfg_v_i(cfg_v_i), .cfg_iters_i(cfg_iters_i), .busy_o(busy_o),
      .load_v_i(load_v_i), .load_data_i(load_data_i), .load_ready_o(load_ready_o),
      .update_row_o(update_row_o), .update_val_o(update_val_o), .en_o(en_o),
      .rd_row_o(rd_row_o), .rd_data_i(rd_data_i), .out_v_o(out_v_o),
      .out_data_o(out_data_o), .out_yumi_i(out_yumi_i), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   // Cell array model: capture on strobe, rotate-left on enable, no reset.
   logic [W-1:0] cells [H];
   always @(posedge clk_i) begin
      for (int r = 0; r < H; r++) begin
         if (update_row_o[r]) cells[r] <= update_val_o;
         if (en_o) cells[r] <= {cells[r][W-2:0], cells[r][W-1]};
      end
   end
   assign rd_data_i = cells[rd_row_o];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard state
   logic [W-1:0] exp_q[$];
   int           stall_row  = -1;
   int           stall_left = 0;
   int           taken      = 0;

   // Monitor/consumer: compare every offered row, take it unless stalling.
   initial begin
      out_yumi_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!reset_n_i || !out_v_o) begin
            out_yumi_i = 1'b0;
            if (!reset_n_i) taken = 0;
         end else begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL out_unexpected: got %0h expected no output", out_data_o);
            end else begin
               check("out_data", out_data_o, exp_q[0]);
            end
            check("rd_row", rd_row_o, taken[2:0]);
            if (taken == stall_row && stall_left > 0) begin
               stall_left--;
               out_yumi_i = 1'b0;
            end else begin
               out_yumi_i = 1'b1;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               taken = (taken + 1) % H;
            end
         end
      end
   end

   // Per-cycle checker: strobe model, enable count, exclusivity, latency.
   int cyc = 0, en_cnt = 0, excl_bad = 0, tb_row = 0, done_lat = 0, done_en = 0;
   bit done_flag = 1'b0;
   initial begin
      forever begin
         @(negedge clk_i);
         if (reset_n_i) begin
            bit beat;
            if (cfg_v_i && !busy_o) begin
               cyc = 0; en_cnt = 0; excl_bad = 0; tb_row = 0;
            end else begin
               cyc++;
            end
            if (en_o) en_cnt++;
            if (en_o && update_row_o != '0) excl_bad++;
            beat = load_v_i && load_ready_o;
            check("upd_row", update_row_o, beat ? (8'b1 << tb_row) : 8'h0);
            if (beat) begin
               check("upd_val", update_val_o, load_data_i);
               tb_row = (tb_row + 1) % H;
            end
            if (done_o) begin
               done_flag = 1'b1;
               done_lat  = cyc;
               done_en   = en_cnt;
            end
         end
      end
   end

   logic [W-1:0] ld_rows [H];

   task automatic start(input logic [IW-1:0] it);
      @(posedge clk_i); #1;
      done_flag   = 1'b0;
      cfg_v_i     = 1'b1;
      cfg_iters_i = it;
      @(posedge clk_i); #1;
      cfg_v_i     = 1'b0;
   endtask

   task automatic load(input bit toggle);
      int idx = 0, k = 0;
      while (idx < H && k < 100) begin
         load_v_i    = toggle ? (k % 2 == 0) : 1'b1;
         load_data_i = load_v_i ? ld_rows[idx] : ~ld_rows[idx];
         @(negedge clk_i);
         if (load_v_i && load_ready_o) idx++;
         k++;
         @(posedge clk_i); #1;
      end
      load_v_i = 1'b0;
      if (idx < H) begin
         n_cmp++; n_bad++;
         $display("FAIL load_timeout: got %0d beats expected %0d", idx, H);
      end
   endtask

   task automatic wait_done(input string nm, input int exp_lat, input int exp_en);
      int g = 0;
      while (!done_flag && g < 300) begin
         @(negedge clk_i); #1;
         g++;
      end
      if (!done_flag) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_done_timeout: got no done_o expected done_o", nm);
      end else begin
         check({nm, "_latency"}, done_lat, exp_lat);
         check({nm, "_en_cycles"}, done_en, exp_en);
         check({nm, "_en_upd_excl"}, excl_bad, 0);
         check({nm, "_idle_at_done"}, busy_o, 1'b0);
         check({nm, "_rows_left"}, exp_q.size(), 0);
      end
      done_flag = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n_i = 1'b0; cfg_v_i = 1'b0; cfg_iters_i = '0;
      load_v_i = 1'b0; load_data_i = '0;
`ifdef BSG_ACM_CTRL_ABORT_EN
      abort_i = 1'b0;
`endif
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_busy", busy_o, 1'b0);
      check("rst_en", en_o, 1'b0);
      check("rst_ready", load_ready_o, 1'b0);
      check("rst_out_v", out_v_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_upd_row", update_row_o, 8'h00);
      reset_n_i = 1'b1;

      // Walking-one rows, 3 iterations: each row rotated left by 3.
      for (int k = 0; k < H; k++) ld_rows[k] = 8'h01 << k;
      exp_q = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
      start(16'd3); load(1'b0); wait_done("t2", 20, 3);

      // iters=0 skips RUN: rows come back unchanged.
      for (int k = 0; k < H; k++) ld_rows[k] = (k % 2 == 0) ? 8'hA5 : 8'h5A;
      exp_q = '{8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
      start(16'd0); load(1'b0); wait_done("t3", 17, 0);

      // Gapped load beats and a 5-cycle consumer stall on row 2, iters=2.
      ld_rows = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h81, 8'h42, 8'h24, 8'h18};
      exp_q = '{8'h0C, 8'h30, 8'hC0, 8'h03, 8'h06, 8'h09, 8'h90, 8'h60};
      stall_row = 2; stall_left = 5;
      start(16'd2); load(1'b1); wait_done("t4", 31, 2);
      stall_row = -1;

      // cfg_v_i during RUN with iters=7 must not change the running frame.
      ld_rows = '{8'h0F, 8'hF0, 8'h33, 8'hCC, 8'h55, 8'hAA, 8'h01, 8'hFE};
      exp_q = '{8'h78, 8'h87, 8'h99, 8'h66, 8'hAA, 8'h55, 8'h08, 8'hF7};
      start(16'd3); load(1'b0);
      check("t5_in_run", en_o, 1'b1);
      cfg_v_i = 1'b1; cfg_iters_i = 16'd7;
      @(posedge clk_i); #1;
      cfg_v_i = 1'b0;
      wait_done("t5", 20, 3);
      repeat (3) @(posedge clk_i);
      #1;
      check("t5_no_restart", busy_o, 1'b0);

      // Asynchronous reset in the middle of RUN.
      for (int k = 0; k < H; k++) ld_rows[k] = 8'(k);
      start(16'd20); load(1'b0);
      @(posedge clk_i); #1;
      check("t1_pre_en", en_o, 1'b1);
      reset_n_i = 1'b0;
      #1;
      check("t1_busy", busy_o, 1'b0);
      check("t1_en", en_o, 1'b0);
      check("t1_ready", load_ready_o, 1'b0);
      check("t1_out_v", out_v_o, 1'b0);
      @(posedge clk_i); #1;
      reset_n_i = 1'b1;

      // Clean frame after reset, iters=1.
      for (int k = 0; k < H; k++) ld_rows[k] = 8'h80 >> k;
      exp_q = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
      start(16'd1); load(1'b0); wait_done("t1b", 18, 1);

`ifdef BSG_ACM_CTRL_ABORT_EN
      // Abort on the 4th load beat, then a fresh frame from row 0.
      start(16'd3);
      for (int k = 0; k < 4; k++) begin
         load_v_i = 1'b1; load_data_i = 8'(k + 1); abort_i = (k == 3);
         @(posedge clk_i); #1;
      end
      load_v_i = 1'b0; abort_i = 1'b0;
      check("t6_busy", busy_o, 1'b0);
      check("t6_ready", load_ready_o, 1'b0);
      repeat (25) @(posedge clk_i);
      #1;
      check("t6_no_done", done_flag, 1'b0);
      for (int k = 0; k < H; k++) ld_rows[k] = 8'h01 << k;
      exp_q = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
      start(16'd3); load(1'b0); wait_done("t6", 20, 3);
`endif

      repeat (2) @(posedge clk_i);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
